// File: rtl/fp_pack.sv
// fp_pack: rebias, truncate and NaN-box unpacked FP fields into FLEN storage format, behind a
// two-stage valid/ready pipeline. Define FPACK_NAN_PAYLOAD_EN to keep NaN sign and payload.
module fp_pack #(
   // Discrete parameters mirroring the cvw_t fields this block consumes
   parameter int FLEN          = 64,
   parameter int NE            = 11,
   parameter int NF            = 52,
   parameter int FMTBITS       = 2,
   parameter bit F_SUPPORTED   = 1'b1,
   parameter bit D_SUPPORTED   = 1'b1,
   parameter bit ZFH_SUPPORTED = 1'b0,
   parameter bit Q_SUPPORTED   = 1'b0,
   parameter int NE_S = 8,  parameter int NF_S = 23,
   parameter int NE_D = 11, parameter int NF_D = 52,
   parameter int NE_H = 5,  parameter int NF_H = 10,
   parameter int NE_Q = 15, parameter int NF_Q = 112
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               Flush,
   input  logic               InValid,
   output logic               InReady,
   input  logic               Sgn,
   input  logic [NE-1:0]      Exp,
   input  logic [NF:0]        Man,
   input  logic [FMTBITS-1:0] Fmt,
   input  logic               NaN,
   input  logic               Inf,
   input  logic               Zero,
   input  logic               Subnorm,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [FLEN-1:0]    Res
);

   localparam int EW = $clog2(NE + 1);
   localparam int FW = $clog2(NF + 1);
   localparam int NE_L = Q_SUPPORTED ? NE_Q : D_SUPPORTED ? NE_D : F_SUPPORTED ? NE_S : NE_H;
   localparam int NF_L = Q_SUPPORTED ? NF_Q : D_SUPPORTED ? NF_D : F_SUPPORTED ? NF_S : NF_H;
   localparam logic [NE-1:0] BIAS = NE'((1 << (NE - 1)) - 1);

   logic          manLeadUnused;
   logic          live_q;
   logic          v1_q, v1_d, v2_q, v2_d;
   logic          adv1, adv2, accept;
   logic          sgn1_q, sgn1_d;
   logic [NE-1:0] exp1_q, exp1_d;
   logic [NF-1:0] frac1_q, frac1_d;
   logic [3:0]    cls1_q, cls1_d;
   logic [EW-1:0] ne1_q, ne1_d;
   logic [FW-1:0] nf1_q, nf1_d;
   logic [FLEN-1:0] res2_q, res2_d;

   logic [EW-1:0] neSel;
   logic [FW-1:0] nfSel;
   logic [NE-1:0] biasSel, expMask;
   logic [NE-1:0] expOnes, expA;
   logic [NF-1:0] qBit, fracA;
   logic          sgnA;
   logic [FLEN-1:0] box, resAsm;

   // The explicit leading bit carries no information once the class flags are known
   assign manLeadUnused = Man[NF];

   assign adv2     = !v2_q || OutReady;
   assign adv1     = !v1_q || adv2;
   assign InReady  = live_q && !Flush && adv1;
   assign accept   = InValid && InReady;
   assign OutValid = v2_q;
   assign Res      = res2_q;

   // Unsupported formats fall back to the widest supported format
   always_comb begin
      neSel = EW'(NE_L);
      nfSel = FW'(NF_L);
      if (Fmt == FMTBITS'(0) && F_SUPPORTED) begin
         neSel = EW'(NE_S);
         nfSel = FW'(NF_S);
      end else if (Fmt == FMTBITS'(1) && D_SUPPORTED) begin
         neSel = EW'(NE_D);
         nfSel = FW'(NF_D);
      end else if (Fmt == FMTBITS'(2) && ZFH_SUPPORTED) begin
         neSel = EW'(NE_H);
         nfSel = FW'(NF_H);
      end else if (Fmt == FMTBITS'(3) && Q_SUPPORTED) begin
         neSel = EW'(NE_Q);
         nfSel = FW'(NF_Q);
      end
   end

   always_comb begin
      biasSel = (NE'(1) << (neSel - EW'(1))) - NE'(1);
      expMask = (NE'(1) << neSel) - NE'(1);
      v1_d    = v1_q;
      sgn1_d  = sgn1_q;
      exp1_d  = exp1_q;
      frac1_d = frac1_q;
      cls1_d  = cls1_q;
      ne1_d   = ne1_q;
      nf1_d   = nf1_q;
      if (Flush) begin
         v1_d = 1'b0;
      end else if (adv1) begin
         v1_d = accept;
         if (accept) begin
            sgn1_d  = Sgn;
            exp1_d  = (Exp - BIAS + biasSel) & expMask;
            frac1_d = Man[NF-1:0] >> (FW'(NF) - nfSel);
            cls1_d  = {NaN, Inf, Zero, Subnorm};
            ne1_d   = neSel;
            nf1_d   = nfSel;
         end
      end
   end

   // Special-value encoding and boxing happen on the registered stage-1 fields
   always_comb begin
      expOnes = (NE'(1) << ne1_q) - NE'(1);
      qBit    = NF'(1) << (nf1_q - FW'(1));
      sgnA    = sgn1_q;
      expA    = exp1_q;
      fracA   = frac1_q;
      if (cls1_q[3]) begin
`ifdef FPACK_NAN_PAYLOAD_EN
         sgnA  = sgn1_q;
         expA  = expOnes;
         fracA = frac1_q | qBit;
`else
         sgnA  = 1'b0;
         expA  = expOnes;
         fracA = qBit;
`endif
      end else if (cls1_q[2]) begin
         expA  = expOnes;
         fracA = '0;
      end else if (cls1_q[1]) begin
         expA  = '0;
         fracA = '0;
      end else if (cls1_q[0]) begin
         expA  = '0;
      end
      box    = (({FLEN{1'b1}} << nf1_q) << ne1_q) << 1;
      resAsm = box | ((FLEN'(sgnA) << nf1_q) << ne1_q) | (FLEN'(expA) << nf1_q) | FLEN'(fracA);
   end

   always_comb begin
      v2_d   = v2_q;
      res2_d = res2_q;
      if (Flush) begin
         v2_d = 1'b0;
      end else if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            res2_d = resAsm;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live_q  <= 1'b0;
         v1_q    <= 1'b0;
         sgn1_q  <= 1'b0;
         exp1_q  <= '0;
         frac1_q <= '0;
         cls1_q  <= '0;
         ne1_q   <= '0;
         nf1_q   <= '0;
         v2_q    <= 1'b0;
         res2_q  <= '0;
      end else begin
         live_q  <= 1'b1;
         v1_q    <= v1_d;
         sgn1_q  <= sgn1_d;
         exp1_q  <= exp1_d;
         frac1_q <= frac1_d;
         cls1_q  <= cls1_d;
         ne1_q   <= ne1_d;
         nf1_q   <= nf1_d;
         v2_q    <= v2_d;
         res2_q  <= res2_d;
      end
   end

endmodule

// File: tb/tb_fp_pack.sv
// tb_fp_pack: scoreboard bench for fp_pack (FLEN=64, single/double supported) with directed
// vectors, backpressure, flush and asynchronous reset scenarios.
module tb_fp_pack;

   localparam logic [3:0] CNORM = 4'b0000;
   localparam logic [3:0] CNAN  = 4'b1000;
   localparam logic [3:0] CINF  = 4'b0100;
   localparam logic [3:0] CZERO = 4'b0010;
   localparam logic [3:0] CSUB  = 4'b0001;
   localparam logic [52:0] ONE  = 53'h10_0000_0000_0000;
`ifdef FPACK_NAN_PAYLOAD_EN
   localparam logic [63:0] NAN_S = 64'hFFFFFFFF_FFC00005;
`else
   localparam logic [63:0] NAN_S = 64'hFFFFFFFF_7FC00000;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        Flush = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic        Sgn = 1'b0;
   logic [10:0] Exp = '0;
   logic [52:0] Man = '0;
   logic [1:0]  Fmt = '0;
   logic        NaN = 1'b0, Inf = 1'b0, Zero = 1'b0, Subnorm = 1'b0;
   logic        OutValid;
   logic        OutReady = 1'b1;
   logic [63:0] Res;

   logic [63:0] sb[$];
   int          tests = 0;
   int          fails = 0;
   int          acceptCnt = 0;
   logic        holdValid = 1'b0;
   logic [63:0] holdRes = '0;

   fp_pack dut (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .Sgn(Sgn), .Exp(Exp), .Man(Man), .Fmt(Fmt), .NaN(NaN), .Inf(Inf), .Zero(Zero),
      .Subnorm(Subnorm), .OutValid(OutValid), .OutReady(OutReady), .Res(Res)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic driveFields(input logic [1:0] f, input logic s, input logic [10:0] e,
                              input logic [52:0] m, input logic [3:0] c);
      Fmt = f; Sgn = s; Exp = e; Man = m;
      {NaN, Inf, Zero, Subnorm} = c;
   endtask

   // Offers one input and pushes its expected result at the accepting edge
   task automatic applyStimulus(input logic [1:0] f, input logic s, input logic [10:0] e,
                                input logic [52:0] m, input logic [3:0] c, input logic [63:0] expRes);
      int waitCnt = 0;
      bit done = 1'b0;
      @(negedge clk);
      driveFields(f, s, e, m, c);
      InValid = 1'b1;
      while (!done) begin
         #1;
         if (InReady) begin
            sb.push_back(expRes);
            acceptCnt++;
            @(posedge clk);
            #1 InValid = 1'b0;
            done = 1'b1;
         end else if (waitCnt >= 50) begin
            checkOutput("accept_timeout", 64'(InReady), 64'd1);
            InValid = 1'b0;
            done = 1'b1;
         end else begin
            waitCnt++;
            @(negedge clk);
         end
      end
   endtask

   // Monitor: pops and compares on every output transfer, and checks hold stability
   always @(negedge clk) begin
      #2;
      if (!reset_n || !OutValid) begin
         holdValid = 1'b0;
      end else begin
         if (holdValid) checkOutput("res_stable", Res, holdRes);
         if (OutReady) begin
            holdValid = 1'b0;
            if (sb.size() == 0) checkOutput("unexpected_out", Res, 64'h0);
            else checkOutput("res", Res, sb.pop_front());
         end else begin
            holdValid = 1'b1;
            holdRes   = Res;
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_outvalid", 64'(OutValid), 64'd0);
      checkOutput("rst_inready", 64'(InReady), 64'd0);
      checkOutput("rst_res", Res, 64'd0);
      reset_n = 1'b1;
      #1 checkOutput("inready_pre_edge", 64'(InReady), 64'd0);
      @(posedge clk);
      #1 checkOutput("inready_post_edge", 64'(InReady), 64'd1);

      // Back-to-back directed vectors under continuous ready
      applyStimulus(2'b00, 1'b0, 11'd1023, ONE, CNORM, 64'hFFFFFFFF_3F800000);
      applyStimulus(2'b01, 1'b1, 11'd1024, ONE, CNORM, 64'hC000000000000000);
      applyStimulus(2'b00, 1'b1, 11'd0, ONE, CINF, 64'hFFFFFFFF_FF800000);
      applyStimulus(2'b00, 1'b1, 11'd2047, 53'h10_0000_A000_0005, CNAN, NAN_S);
      applyStimulus(2'b01, 1'b0, 11'd2047, ONE, CNAN, 64'h7FF8000000000000);
      applyStimulus(2'b00, 1'b0, 11'd0, 53'h08_0000_0000_0000, CSUB, 64'hFFFFFFFF_00400000);
      applyStimulus(2'b00, 1'b1, 11'd0, '0, CZERO, 64'hFFFFFFFF_80000000);
      applyStimulus(2'b01, 1'b1, 11'd0, '0, CZERO, 64'h8000000000000000);
      applyStimulus(2'b01, 1'b0, 11'd1023, 53'h18_0000_0000_0000, CNORM, 64'h3FF8000000000000);
      applyStimulus(2'b00, 1'b0, 11'd1023, 53'h1F_FFFF_FFFF_FFFF, CNORM, 64'hFFFFFFFF_3FFFFFFF);
      applyStimulus(2'b00, 1'b0, 11'd897, ONE, CNORM, 64'hFFFFFFFF_00800000);
      applyStimulus(2'b01, 1'b0, 11'd1030, 53'h11_2345_6789_ABCD, CNORM, 64'h406123456789ABCD);
      applyStimulus(2'b10, 1'b0, 11'd1023, ONE, CNORM, 64'h3FF0000000000000);
      applyStimulus(2'b11, 1'b1, 11'd1024, ONE, CNORM, 64'hC000000000000000);
      drain();

      // Backpressure: four offers, OutReady low for three cycles
      @(negedge clk);
      OutReady = 1'b0;
      acceptCnt = 0;
      fork
         begin
            applyStimulus(2'b00, 1'b0, 11'd1023, ONE, CNORM, 64'hFFFFFFFF_3F800000);
            applyStimulus(2'b01, 1'b1, 11'd1024, ONE, CNORM, 64'hC000000000000000);
            applyStimulus(2'b00, 1'b0, 11'd897, ONE, CNORM, 64'hFFFFFFFF_00800000);
            applyStimulus(2'b01, 1'b0, 11'd1023, 53'h18_0000_0000_0000, CNORM, 64'h3FF8000000000000);
         end
         begin
            repeat (3) @(negedge clk);
            #1;
            checkOutput("bp_accepted", 64'(acceptCnt), 64'd2);
            checkOutput("bp_inready_low", 64'(InReady), 64'd0);
            @(negedge clk);
            OutReady = 1'b1;
         end
      join
      drain();
      checkOutput("bp_total_accepted", 64'(acceptCnt), 64'd4);

      // Flush with two entries in flight plus a simultaneous offer
      @(negedge clk);
      OutReady = 1'b0;
      applyStimulus(2'b00, 1'b0, 11'd1023, ONE, CNORM, 64'hFFFFFFFF_3F800000);
      applyStimulus(2'b01, 1'b1, 11'd1024, ONE, CNORM, 64'hC000000000000000);
      @(negedge clk);
      Flush = 1'b1;
      driveFields(2'b00, 1'b1, 11'd0, ONE, CINF);
      InValid = 1'b1;
      #1 checkOutput("flush_inready", 64'(InReady), 64'd0);
      @(posedge clk);
      #1;
      Flush = 1'b0;
      InValid = 1'b0;
      sb.delete();
      checkOutput("flush_outvalid", 64'(OutValid), 64'd0);
      @(negedge clk);
      OutReady = 1'b1;
      repeat (4) @(posedge clk);

      // Asynchronous reset in the middle of a stream
      @(negedge clk);
      OutReady = 1'b0;
      applyStimulus(2'b00, 1'b0, 11'd1023, ONE, CNORM, 64'hFFFFFFFF_3F800000);
      applyStimulus(2'b01, 1'b1, 11'd1024, ONE, CNORM, 64'hC000000000000000);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_outvalid", 64'(OutValid), 64'd0);
      checkOutput("async_rst_res", Res, 64'd0);
      checkOutput("async_rst_inready", 64'(InReady), 64'd0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      OutReady = 1'b1;
      @(posedge clk);
      applyStimulus(2'b00, 1'b1, 11'd0, ONE, CINF, 64'hFFFFFFFF_FF800000);
      checkOutput("latency_cycle1", 64'(OutValid), 64'd0);
      @(posedge clk);
      #1 checkOutput("latency_cycle2", 64'(OutValid), 64'd1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
